vs_spi_responder: RTL and testbench
===================================

VS_SPI_RESPONDER -- requirements
Module: vs_spi_responder

Interface
REQ-001 Parameter: FIFO_DEPTH, 64, SDI byte FIFO depth (power of two).
REQ-002 Parameter: DREQ_MARGIN, 32, minimum free FIFO bytes for o_DREQ=1.
REQ-003 Parameter: SCI_BUSY, 16, clk cycles o_DREQ is held low after an SCI write.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- i_XRST  in  1  decoder hard reset, active low
- i_XCS  in  1  SCI chip select, active low
- i_XDCS  in  1  SDI chip select, active low
- i_SCK  in  1  serial clock, asynchronous to clk
- i_SI  in  1  serial data in, MSB first
- o_SO  out  1  SCI read data
- o_DREQ  out  1  data request to master
- o_data  out  8  FIFO head byte
- o_data_valid  out  1  FIFO non-empty
- i_data_ready  in  1  consumer pop strobe
- o_MODE  out  16  SCI reg 0x0
- o_CLOCKF  out  16  SCI reg 0x3
- o_VOL  out  16  SCI reg 0xB
- o_overflow  out  1  sticky SDI overflow flag

Function
REQ-006 i_SCK, i_SI, i_XCS, i_XDCS and i_XRST SHALL each pass through a 2-flop synchronizer. SCK edges SHALL be detected in the clk domain. clk SHALL be at least 4x the SCK rate.
REQ-007 SI SHALL be sampled on a synchronized SCK rising edge. o_SO SHALL update on the falling edge.
REQ-008 SCI FSM states: IDLE, OPCODE (8 bits), ADDR (8 bits), DATA (16 bits), DONE.
- Falling i_XCS: IDLE->OPCODE, bit counter cleared.
- Rising i_XCS in any state: return to IDLE.
REQ-009 Write opcode 0x02: after bit 32, data[15:0] SHALL be written to reg[addr[3:0]] in the clk cycle after that edge. An address of 0x10 or above SHALL be discarded.
REQ-010 Any opcode other than 0x02/0x03 SHALL discard the frame. The FSM SHALL then wait in DONE until i_XCS rises.
REQ-011 If i_XCS rises before bit 32, no register write SHALL occur.
REQ-012 SDI path: while i_XDCS is low and i_XCS is high, each 8 sampled bits SHALL form a byte pushed to the FIFO. A partial byte SHALL be discarded when i_XDCS rises.
REQ-013 If i_XCS and i_XDCS are both low, SCI SHALL take priority and SDI bits SHALL be ignored.
REQ-014 A push to a full FIFO SHALL drop the byte and set o_overflow. o_overflow SHALL clear only on reset or i_XRST low.
REQ-015 o_data_valid SHALL equal FIFO non-empty. A pop SHALL occur when o_data_valid and i_data_ready are both high. A simultaneous push and pop SHALL keep the count unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 o_DREQ SHALL be 1 only when all hold: free space >= DREQ_MARGIN, the SCI busy counter is zero, and synchronized i_XRST is high.
REQ-017 The SCI busy counter SHALL load SCI_BUSY on each register write and decrement to 0.
REQ-018 i_XRST low SHALL act as a soft reset: registers return to defaults, FIFO flushed, FSM to IDLE, o_DREQ=0.

Reset
REQ-019 On rst_n low:
- all state SHALL clear;
- o_DREQ=0, o_SO=0, o_data_valid=0, o_overflow=0, o_data=0;
- o_MODE=16'h0800, o_CLOCKF=0, o_VOL=0; all other registers 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no partial register write.

Configuration
REQ-021 Macro SCI_READ_EN defined:
- opcode 0x03 SHALL be decoded;
- after bit 16, reg[addr[3:0]] SHALL load into a shift-out register, driven on o_SO MSB first over the next 16 falling SCK edges.
- Undefined: opcode 0x03 SHALL be treated as unknown and o_SO SHALL be tied to 0.

Structure
REQ-022 Package vs_spi_pkg SHALL hold:
- opcode constants (0x02 write, 0x03 read);
- register addresses (MODE 0x0, CLOCKF 0x3, VOL 0xB);
- register reset defaults;
- the SCI FSM state typedef.
REQ-023 The FIFO SHALL be the sub-module byte_fifo (synchronous, count output). Synchronizers SHALL stay inline.

Verification
REQ-024 SCI write 32'h02000804 then 32'h020B0000 -> o_MODE=16'h0804, o_VOL=16'h0000; o_DREQ low for 16 cycles after each write.
REQ-025 i_XCS raised after 20 bits of 32'h020B1234 -> o_VOL unchanged; FSM back in IDLE.
REQ-026 SDI bytes 0xA5, 0x3C with i_data_ready=1 -> o_data reads 0xA5 then 0x3C; o_data_valid falls after the second pop.
REQ-027 Push 33 bytes, no pops -> o_DREQ falls at the 33rd byte. Push 64 more -> o_overflow=1 and count stays 64.
REQ-028 i_XRST pulsed low with 10 bytes queued -> FIFO empty, o_MODE=16'h0800, o_DREQ=1 after release.
REQ-029 With SCI_READ_EN, read 0x03 0x0B after writing VOL=16'hBEEF -> o_SO shifts out 1011111011101111.

Source files
------------

// File: rtl/vs_spi_pkg.sv
// Shared definitions for the VS-style SPI responder: SCI opcodes, register map,
// register reset values and the SCI frame state type.
package vs_spi_pkg;

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   localparam logic [3:0] ADDR_MODE   = 4'h0;
   localparam logic [3:0] ADDR_CLOCKF = 4'h3;
   localparam logic [3:0] ADDR_VOL    = 4'hB;

   localparam logic [15:0] MODE_DEFAULT   = 16'h0800;
   localparam logic [15:0] CLOCKF_DEFAULT = 16'h0000;
   localparam logic [15:0] VOL_DEFAULT    = 16'h0000;

   localparam int NUM_REGS = 16;

   typedef enum logic [2:0] {
      SCI_IDLE   = 3'd0,
      SCI_OPCODE = 3'd1,
      SCI_ADDR   = 3'd2,
      SCI_DATA   = 3'd3,
      SCI_DONE   = 3'd4
   } sci_state_e;

   function automatic logic [15:0] reg_default(input logic [3:0] addr);
      logic [15:0] value;
      case (addr)
         ADDR_MODE:   value = MODE_DEFAULT;
         ADDR_CLOCKF: value = CLOCKF_DEFAULT;
         ADDR_VOL:    value = VOL_DEFAULT;
         default:     value = 16'h0000;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count and flush. A push into a full FIFO
// is dropped (flagged on dropped) unless a pop frees a slot in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   srst,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   dropped
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == CW'(DEPTH));
   assign pop_s   = pop & ~empty_s;
   assign push_s  = push & (~full_s | pop_s);

   assign empty   = empty_s;
   assign count   = count_r;
   assign dropped = push & ~push_s;
   assign rd_data = empty_s ? 8'h00 : mem_r[rd_ptr_r];

   // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (srst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/vs_spi_responder.sv
// VS-style SPI responder: SCI register port plus SDI byte stream into a FIFO.
// Define SCI_READ_EN to build the opcode 0x03 register read-back on o_SO.
module vs_spi_responder
   import vs_spi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 64,
   parameter int DREQ_MARGIN = 32,
   parameter int SCI_BUSY    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_XRST,
   input  logic        i_XCS,
   input  logic        i_XDCS,
   input  logic        i_SCK,
   input  logic        i_SI,
   output logic        o_SO,
   output logic        o_DREQ,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   input  logic        i_data_ready,
   output logic [15:0] o_MODE,
   output logic [15:0] o_CLOCKF,
   output logic [15:0] o_VOL,
   output logic        o_overflow
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(SCI_BUSY + 1);

   logic [1:0] sck_sync_r;
   logic [1:0] si_sync_r;
   logic [1:0] xcs_sync_r;
   logic [1:0] xdcs_sync_r;
   logic [1:0] xrst_sync_r;
   logic       sck_d_r;
   logic       xcs_d_r;
   logic       si_s;
   logic       xcs_s;
   logic       xdcs_s;
   logic       srst_s;
   logic       sck_rise_s;
   logic       xcs_fall_s;
   logic       xcs_rise_s;

   // Two-flop synchronizers plus edge history; chip selects reset to their idle (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_r  <= 2'b00;
         si_sync_r   <= 2'b00;
         xcs_sync_r  <= 2'b11;
         xdcs_sync_r <= 2'b11;
         xrst_sync_r <= 2'b00;
         sck_d_r     <= 1'b0;
         xcs_d_r     <= 1'b1;
      end else begin
         sck_sync_r  <= {sck_sync_r[0], i_SCK};
         si_sync_r   <= {si_sync_r[0], i_SI};
         xcs_sync_r  <= {xcs_sync_r[0], i_XCS};
         xdcs_sync_r <= {xdcs_sync_r[0], i_XDCS};
         xrst_sync_r <= {xrst_sync_r[0], i_XRST};
         sck_d_r     <= sck_sync_r[1];
         xcs_d_r     <= xcs_sync_r[1];
      end
   end

   assign si_s       = si_sync_r[1];
   assign xcs_s      = xcs_sync_r[1];
   assign xdcs_s     = xdcs_sync_r[1];
   assign srst_s     = ~xrst_sync_r[1];
   assign sck_rise_s = sck_sync_r[1] & ~sck_d_r;
   assign xcs_fall_s = ~xcs_s & xcs_d_r;
   assign xcs_rise_s = xcs_s & ~xcs_d_r;

   sci_state_e  state_r;
   sci_state_e  state_next;
   logic [4:0]  bit_cnt_r;
   logic [14:0] sci_shift_r;
   logic [15:0] shift_next_s;
   logic        is_write_r;
   logic [7:0]  addr_r;
   logic        wr_en_r;
   logic [3:0]  wr_addr_r;
   logic [15:0] wr_data_r;
   logic        sci_bit_s;
   logic        in_frame_s;
   logic        opcode_ok_s;
   logic [15:0] regs_r [NUM_REGS];

   assign sci_bit_s    = sck_rise_s & ~xcs_s;
   assign shift_next_s = {sci_shift_r, si_s};
   assign in_frame_s   = (state_r == SCI_OPCODE) || (state_r == SCI_ADDR) || (state_r == SCI_DATA);

`ifdef SCI_READ_EN
   assign opcode_ok_s = (shift_next_s[7:0] == OP_WRITE) || (shift_next_s[7:0] == OP_READ);
`else
   assign opcode_ok_s = (shift_next_s[7:0] == OP_WRITE);
`endif

   // SCI frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= SCI_IDLE;
      end else if (srst_s) begin
         state_r <= SCI_IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // SCI next state: XCS rising always aborts back to IDLE.
   always_comb begin
      state_next = state_r;
      if (xcs_rise_s) begin
         state_next = SCI_IDLE;
      end else begin
         case (state_r)
            SCI_IDLE: begin
               if (xcs_fall_s) state_next = SCI_OPCODE;
               else            state_next = SCI_IDLE;
            end
            SCI_OPCODE: begin
               if (sci_bit_s && (bit_cnt_r == 5'd7)) begin
                  if (opcode_ok_s) state_next = SCI_ADDR;
                  else             state_next = SCI_DONE;
               end else begin
                  state_next = SCI_OPCODE;
               end
            end
            SCI_ADDR: begin
               if (sci_bit_s && (bit_cnt_r == 5'd15)) state_next = SCI_DATA;
               else                                   state_next = SCI_ADDR;
            end
            SCI_DATA: begin
               if (sci_bit_s && (bit_cnt_r == 5'd31)) state_next = SCI_DONE;
               else                                   state_next = SCI_DATA;
            end
            SCI_DONE: state_next = SCI_DONE;
            default:  state_next = SCI_IDLE;
         endcase
      end
   end

   // SCI shift/capture; the register write strobe fires one clk after the 32nd bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= 5'd0;
         sci_shift_r <= 15'h0000;
         is_write_r  <= 1'b0;
         addr_r      <= 8'h00;
         wr_en_r     <= 1'b0;
         wr_addr_r   <= 4'h0;
         wr_data_r   <= 16'h0000;
      end else if (srst_s) begin
         bit_cnt_r   <= 5'd0;
         sci_shift_r <= 15'h0000;
         is_write_r  <= 1'b0;
         addr_r      <= 8'h00;
         wr_en_r     <= 1'b0;
         wr_addr_r   <= 4'h0;
         wr_data_r   <= 16'h0000;
      end else begin
         wr_en_r <= 1'b0;
         if (xcs_fall_s) begin
            bit_cnt_r <= 5'd0;
         end else if (sci_bit_s && in_frame_s) begin
            bit_cnt_r   <= bit_cnt_r + 5'd1;
            sci_shift_r <= shift_next_s[14:0];
         end
         if (sci_bit_s && (state_r == SCI_OPCODE) && (bit_cnt_r == 5'd7)) begin
            is_write_r <= (shift_next_s[7:0] == OP_WRITE);
         end
         if (sci_bit_s && (state_r == SCI_ADDR) && (bit_cnt_r == 5'd15)) begin
            addr_r <= shift_next_s[7:0];
         end
         if (sci_bit_s && (state_r == SCI_DATA) && (bit_cnt_r == 5'd31) &&
             is_write_r && (addr_r[7:4] == 4'h0)) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_r[3:0];
            wr_data_r <= shift_next_s;
         end
      end
   end

   // SCI register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= reg_default(4'(i));
      end else if (srst_s) begin
         for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= reg_default(4'(i));
      end else if (wr_en_r) begin
         regs_r[wr_addr_r] <= wr_data_r;
      end
   end

   assign o_MODE   = regs_r[ADDR_MODE];
   assign o_CLOCKF = regs_r[ADDR_CLOCKF];
   assign o_VOL    = regs_r[ADDR_VOL];

`ifdef SCI_READ_EN
   logic [15:0] so_shift_r;
   logic [4:0]  so_cnt_r;
   logic        so_r;
   logic        sck_fall_s;

   assign sck_fall_s = ~sck_sync_r[1] & sck_d_r;

   // Read-back shifter: loads after the address byte, presents one bit per SCK fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         so_shift_r <= 16'h0000;
         so_cnt_r   <= 5'd0;
         so_r       <= 1'b0;
      end else if (srst_s || xcs_s) begin
         so_shift_r <= 16'h0000;
         so_cnt_r   <= 5'd0;
         so_r       <= 1'b0;
      end else if (sci_bit_s && (state_r == SCI_ADDR) && (bit_cnt_r == 5'd15) && !is_write_r) begin
         so_shift_r <= (shift_next_s[7:4] == 4'h0) ? regs_r[shift_next_s[3:0]] : 16'h0000;
         so_cnt_r   <= 5'd16;
      end else if (sck_fall_s) begin
         if (so_cnt_r != 5'd0) begin
            so_r       <= so_shift_r[15];
            so_shift_r <= {so_shift_r[14:0], 1'b0};
            so_cnt_r   <= so_cnt_r - 5'd1;
         end else begin
            so_r <= 1'b0;
         end
      end
   end

   assign o_SO = so_r;
`else
   assign o_SO = 1'b0;
`endif

   logic [6:0] sdi_shift_r;
   logic [2:0] sdi_cnt_r;
   logic       push_r;
   logic [7:0] push_data_r;
   logic       sdi_active_s;

   assign sdi_active_s = ~xdcs_s & xcs_s;

   // SDI byte assembly; SCI has priority and a partial byte is dropped when XDCS is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdi_shift_r <= 7'h00;
         sdi_cnt_r   <= 3'd0;
         push_r      <= 1'b0;
         push_data_r <= 8'h00;
      end else if (srst_s) begin
         sdi_shift_r <= 7'h00;
         sdi_cnt_r   <= 3'd0;
         push_r      <= 1'b0;
         push_data_r <= 8'h00;
      end else begin
         push_r <= 1'b0;
         if (xdcs_s) begin
            sdi_cnt_r <= 3'd0;
         end else if (sck_rise_s && sdi_active_s) begin
            sdi_shift_r <= {sdi_shift_r[5:0], si_s};
            sdi_cnt_r   <= sdi_cnt_r + 3'd1;
            if (sdi_cnt_r == 3'd7) begin
               push_r      <= 1'b1;
               push_data_r <= {sdi_shift_r, si_s};
            end
         end
      end
   end

   logic [CW-1:0] fifo_count_s;
   logic [CW-1:0] free_s;
   logic          fifo_empty_s;
   logic          fifo_dropped_s;
   logic          pop_s;

   assign pop_s        = ~fifo_empty_s & i_data_ready;
   assign o_data_valid = ~fifo_empty_s;
   assign free_s       = CW'(FIFO_DEPTH) - fifo_count_s;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .srst      (srst_s),
      .push      (push_r),
      .push_data (push_data_r),
      .pop       (pop_s),
      .rd_data   (o_data),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s),
      .dropped   (fifo_dropped_s)
   );

   logic [BW-1:0] busy_r;
   logic [BW-1:0] busy_next_s;
   logic          dreq_r;
   logic          overflow_r;

   // Busy countdown after each register write.
   always_comb begin
      busy_next_s = busy_r;
      if (wr_en_r) begin
         busy_next_s = BW'(SCI_BUSY);
      end else if (busy_r != {BW{1'b0}}) begin
         busy_next_s = busy_r - BW'(1);
      end else begin
         busy_next_s = busy_r;
      end
   end

   // Busy counter, DREQ (uses next busy so it drops on the write cycle) and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= {BW{1'b0}};
         dreq_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else if (srst_s) begin
         busy_r     <= {BW{1'b0}};
         dreq_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         busy_r     <= busy_next_s;
         dreq_r     <= (free_s >= CW'(DREQ_MARGIN)) && (busy_next_s == {BW{1'b0}});
         overflow_r <= overflow_r | fifo_dropped_s;
      end
   end

   assign o_DREQ     = dreq_r;
   assign o_overflow = overflow_r;

endmodule

// File: tb/tb_vs_spi_responder.sv
// Directed self-checking bench for vs_spi_responder (SCI writes/reads, SDI FIFO,
// DREQ margin and busy window, overflow, XRST soft reset).
module tb_vs_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_XRST;
   logic        i_XCS;
   logic        i_XDCS;
   logic        i_SCK;
   logic        i_SI;
   logic        o_SO;
   logic        o_DREQ;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        i_data_ready;
   logic [15:0] o_MODE;
   logic [15:0] o_CLOCKF;
   logic [15:0] o_VOL;
   logic        o_overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int dreq_low_total = 0;

   vs_spi_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_XRST       (i_XRST),
      .i_XCS        (i_XCS),
      .i_XDCS       (i_XDCS),
      .i_SCK        (i_SCK),
      .i_SI         (i_SI),
      .o_SO         (o_SO),
      .o_DREQ       (o_DREQ),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (i_data_ready),
      .o_MODE       (o_MODE),
      .o_CLOCKF     (o_CLOCKF),
      .o_VOL        (o_VOL),
      .o_overflow   (o_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!o_DREQ) dreq_low_total <= dreq_low_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // SCK period 160 ns (16 clk); SI changes while SCK is low, SO sampled just before each rise.
   task automatic sck_bits(input logic [31:0] val, input int n, output logic [31:0] so_bits);
      so_bits = 32'h0;
      for (int i = n - 1; i >= 0; i--) begin
         i_SI = val[i];
         #80;
         so_bits = {so_bits[30:0], o_SO};
         i_SCK = 1'b1;
         #80;
         i_SCK = 1'b0;
      end
   endtask

   task automatic sci_frame(input logic [31:0] val, input int n, output logic [31:0] so_bits);
      i_XCS = 1'b0;
      #100;
      sck_bits(val, n, so_bits);
      #100;
      i_XCS = 1'b1;
      #200;
   endtask

   task automatic sdi_send(input logic [7:0] b);
      logic [31:0] unused_so;
      sck_bits({24'h0, b}, 8, unused_so);
   endtask

   task automatic pop_one();
      @(negedge clk);
      i_data_ready = 1'b1;
      @(negedge clk);
      i_data_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] so;
      int d0;
      int pops;

      rst_n = 1'b0; i_XRST = 1'b1; i_XCS = 1'b1; i_XDCS = 1'b1;
      i_SCK = 1'b0; i_SI = 1'b0; i_data_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dreq",     32'(o_DREQ), 32'h0);
      check("rst_so",       32'(o_SO), 32'h0);
      check("rst_valid",    32'(o_data_valid), 32'h0);
      check("rst_overflow", 32'(o_overflow), 32'h0);
      check("rst_data",     32'(o_data), 32'h0);
      check("rst_mode",     32'(o_MODE), 32'h0800);
      check("rst_clockf",   32'(o_CLOCKF), 32'h0);
      check("rst_vol",      32'(o_VOL), 32'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("dreq_idle", 32'(o_DREQ), 32'h1);

      // SCI writes and busy windows
      d0 = dreq_low_total; sci_frame(32'h02000804, 32, so);
      check("wr_mode", 32'(o_MODE), 32'h0804);
      check("busy_mode", 32'(dreq_low_total - d0), 32'd16);
      d0 = dreq_low_total; sci_frame(32'h020B0000, 32, so);
      check("wr_vol", 32'(o_VOL), 32'h0000);
      check("mode_kept", 32'(o_MODE), 32'h0804);
      check("busy_vol", 32'(dreq_low_total - d0), 32'd16);
      sci_frame(32'h0203ABCD, 32, so);
      check("wr_clockf", 32'(o_CLOCKF), 32'hABCD);
      d0 = dreq_low_total; sci_frame(32'h02135555, 32, so);
      check("addr_hi_discard", 32'(o_CLOCKF), 32'hABCD);
      check("addr_hi_nobusy", 32'(dreq_low_total - d0), 32'd0);
      d0 = dreq_low_total; sci_frame(32'h05035555, 32, so);
      check("bad_op_discard", 32'(o_CLOCKF), 32'hABCD);
      check("bad_op_nobusy", 32'(dreq_low_total - d0), 32'd0);
      d0 = dreq_low_total; sci_frame(32'h000020B1, 20, so);
      check("trunc_vol", 32'(o_VOL), 32'h0000);
      check("trunc_nobusy", 32'(dreq_low_total - d0), 32'd0);
      d0 = dreq_low_total; sci_frame(32'h020BBEEF, 32, so);
      check("after_trunc_vol", 32'(o_VOL), 32'hBEEF);
      check("busy_beef", 32'(dreq_low_total - d0), 32'd16);
      sci_frame(32'h030B0000, 32, so);
`ifdef SCI_READ_EN
      check("read_vol_so", so, 32'h0000BEEF);
`else
      check("read_off_so", so, 32'h00000000);
`endif
      check("read_no_write", 32'(o_VOL), 32'hBEEF);

      // SDI FIFO path
      i_XDCS = 1'b0; #100;
      sdi_send(8'hA5);
      check("sdi_valid1", 32'(o_data_valid), 32'h1);
      check("sdi_head_a5", 32'(o_data), 32'hA5);
      sdi_send(8'h3C);
      check("sdi_head_still_a5", 32'(o_data), 32'hA5);
      pop_one();
      check("sdi_head_3c", 32'(o_data), 32'h3C);
      check("sdi_valid2", 32'(o_data_valid), 32'h1);
      pop_one();
      check("sdi_empty", 32'(o_data_valid), 32'h0);
      check("sdi_empty_data", 32'(o_data), 32'h0);
      sck_bits(32'h0000000F, 4, so);
      i_XDCS = 1'b1; #100; i_XDCS = 1'b0; #100;
      sdi_send(8'h81);
      check("partial_discard", 32'(o_data), 32'h81);
      pop_one();
      check("partial_empty", 32'(o_data_valid), 32'h0);
      i_XCS = 1'b0; #100;
      sck_bits(32'h000000FF, 8, so);
      #100; i_XCS = 1'b1; #200;
      check("sci_priority", 32'(o_data_valid), 32'h0);

      // fill to DREQ margin, then overflow
      for (int i = 0; i < 32; i++) sdi_send(8'(i));
      check("dreq_32_bytes", 32'(o_DREQ), 32'h1);
      sdi_send(8'd32);
      check("dreq_33_bytes", 32'(o_DREQ), 32'h0);
      for (int i = 33; i < 64; i++) sdi_send(8'(i));
      check("full_no_ovf", 32'(o_overflow), 32'h0);
      sdi_send(8'd64);
      check("ovf_set", 32'(o_overflow), 32'h1);
      for (int i = 65; i < 97; i++) sdi_send(8'(i));
      i_XDCS = 1'b1; #100;
      pops = 0;
      for (int i = 0; i < 70; i++) begin
         if (o_data_valid) begin
            check("drain_data", 32'(o_data), 32'(pops));
            pop_one();
            pops++;
         end else begin
            @(negedge clk);
         end
      end
      check("drain_count", 32'(pops), 32'd64);
      check("ovf_sticky", 32'(o_overflow), 32'h1);
      check("dreq_drained", 32'(o_DREQ), 32'h1);

      // XRST soft reset
      i_XDCS = 1'b0; #100;
      for (int i = 0; i < 10; i++) sdi_send(8'(8'hC0 + i));
      i_XDCS = 1'b1; #100;
      check("xrst_pre_valid", 32'(o_data_valid), 32'h1);
      i_XRST = 1'b0;
      repeat (6) @(negedge clk);
      check("xrst_dreq", 32'(o_DREQ), 32'h0);
      check("xrst_flush", 32'(o_data_valid), 32'h0);
      check("xrst_mode", 32'(o_MODE), 32'h0800);
      check("xrst_clockf", 32'(o_CLOCKF), 32'h0);
      check("xrst_vol", 32'(o_VOL), 32'h0);
      check("xrst_ovf", 32'(o_overflow), 32'h0);
      i_XRST = 1'b1;
      repeat (8) @(negedge clk);
      check("xrst_release_dreq", 32'(o_DREQ), 32'h1);
      check("xrst_release_empty", 32'(o_data_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
